// File: rtl/rx_serial_7e1_pkg.sv
// rx_serial_7e1_pkg: shared state codes, default timing and parity helper for the 7E1 serial link
package rx_serial_7e1_pkg;
  localparam int M_PADRAO = 5208;
  localparam int M_MEIO_PADRAO = 2604;
  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    REPOUSO  = 4'd1,
    START    = 4'd2,
    DADOS    = 4'd3,
    PARIDADE = 4'd4,
    STOP     = 4'd5,
    FINAL    = 4'd6
  } estado_t;
  function automatic logic paridade_par_ok(input logic [6:0] d, input logic p);
    return ~(^{d, p});
  endfunction
endpackage

// File: rtl/rx_serial_7e1_contador_m.sv
// contador_m: modulo-M counter with clear/enable and end-of-count strobe
module contador_m #(
  parameter int M = 5208,
  parameter int N = 13
) (
  input  logic         clock,
  input  logic         zera_i,
  input  logic         conta_i,
  output logic [N-1:0] q_o,
  output logic         fim_o
);
  assign fim_o = q_o == N'(M - 1);
  // count up, wrapping to zero at the terminal count
  always_ff @(posedge clock)
    if (zera_i) q_o <= '0;
    else if (conta_i) q_o <= fim_o ? '0 : q_o + 1'b1;
endmodule

// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1: 7E1 asynchronous serial receiver with parity and framing status
module rx_serial_7e1
  import rx_serial_7e1_pkg::*;
#(
  parameter int M      = M_PADRAO,
  parameter int M_MEIO = M_MEIO_PADRAO,
  parameter int N      = $clog2(M)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       limpa,
  output logic [6:0] dados_ascii,
  output logic       paridade_ok,
  output logic       erro_stop,
  output logic       pronto,
  output logic       tem_dado,
  output logic [3:0] db_estado,
  output logic       db_tick,
  output logic       db_dado_serial
);
  estado_t estado_q;
  logic sinc1_q, rx_s, ant_q;
  logic [2:0] idx_q;
  logic [6:0] desl_q;
  logic par_q, stop_q;
  logic [N-1:0] cnt;
  logic fim, conta, tick;
  assign conta = estado_q inside {START, DADOS, PARIDADE, STOP};
  assign tick = (estado_q == START) ? cnt == N'(M_MEIO - 1) : conta & fim;
  assign db_tick = tick;
  assign db_dado_serial = rx_s;
  assign db_estado = estado_q;
  contador_m #(.M(M), .N(N)) u_cnt (
    .clock  (clock),
    .zera_i (reset | ~conta | (estado_q == START & tick)),
    .conta_i(conta),
    .q_o    (cnt),
    .fim_o  (fim)
  );
  // two-stage synchroniser plus a one-cycle history; the history resets low so
  // the synchroniser's reset value of 1 is never taken as a real idle line
  always_ff @(posedge clock)
    if (reset) {sinc1_q, rx_s, ant_q} <= 3'b110;
    else {sinc1_q, rx_s, ant_q} <= {dado_serial, sinc1_q, rx_s};
  // frame FSM with registered character and status outputs
  always_ff @(posedge clock)
    if (reset) begin
      estado_q <= INICIAL;
      idx_q <= '0;
      desl_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      dados_ascii <= '0;
      paridade_ok <= 1'b0;
      erro_stop <= 1'b0;
      pronto <= 1'b0;
      tem_dado <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (limpa) tem_dado <= 1'b0;
      case (estado_q)
        INICIAL: if (rx_s & sinc1_q & ant_q) estado_q <= REPOUSO;
        REPOUSO: if (ant_q & ~rx_s) estado_q <= START;
        START: if (tick) begin
          idx_q <= '0;
          estado_q <= rx_s ? REPOUSO : DADOS;
        end
        DADOS: if (tick) begin
          desl_q <= {rx_s, desl_q[6:1]};
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd6) estado_q <= PARIDADE;
        end
        PARIDADE: if (tick) begin
          par_q <= rx_s;
          estado_q <= STOP;
        end
        STOP: if (tick) begin
          stop_q <= rx_s;
          estado_q <= FINAL;
        end
        FINAL: begin
          dados_ascii <= desl_q;
          paridade_ok <= paridade_par_ok(desl_q, par_q);
          erro_stop <= ~stop_q;
          pronto <= 1'b1;
          tem_dado <= 1'b1;
          estado_q <= stop_q ? REPOUSO : INICIAL;
        end
        default: estado_q <= INICIAL;
      endcase
    end
endmodule

// File: tb/tb_rx_serial_7e1.sv
// tb_rx_serial_7e1: table-driven and scoreboard bench for the 7E1 receiver
module tb_rx_serial_7e1;
  localparam int M = 32;
  localparam int MM = 16;
  typedef struct {logic [6:0] c; logic p; logic s; logic ok; logic es;} vec_t;
  typedef struct {logic [6:0] c; logic ok; logic es;} exp_t;
  logic clock = 1'b0, reset, dado_serial, limpa, limpa_man, arm_fin;
  logic [6:0] dados_ascii;
  logic paridade_ok, erro_stop, pronto, tem_dado, db_tick, db_dado_serial;
  logic [3:0] db_estado;
  int total = 0, bad = 0, n_pronto = 0, n_tick = 0, np, nt;
  exp_t sb[$];
  exp_t e;
  vec_t tab[5];
  always #5 clock = ~clock;
  assign limpa = limpa_man | (arm_fin & (db_estado == 4'd6));
  rx_serial_7e1 #(.M(M), .M_MEIO(MM)) dut (
    .clock(clock), .reset(reset), .dado_serial(dado_serial), .limpa(limpa),
    .dados_ascii(dados_ascii), .paridade_ok(paridade_ok), .erro_stop(erro_stop),
    .pronto(pronto), .tem_dado(tem_dado), .db_estado(db_estado),
    .db_tick(db_tick), .db_dado_serial(db_dado_serial)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask
  task automatic linha(input logic b, input int n);
    dado_serial = b;
    repeat (n) @(negedge clock);
  endtask
  task automatic send(input logic [6:0] c, input logic p, input logic s);
    linha(1'b0, M);
    for (int i = 0; i < 7; i++) linha(c[i], M);
    linha(p, M);
    linha(s, M);
  endtask
  task automatic pulse_limpa();
    limpa_man = 1'b1;
    @(negedge clock);
    limpa_man = 1'b0;
  endtask
  always @(negedge clock) begin
    if (db_tick) n_tick++;
    if (pronto) begin
      n_pronto++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pronto_extra: got pronto=1 char=%0h want no frame", dados_ascii);
      end else begin
        e = sb.pop_front();
        chk("ascii", 32'(dados_ascii), 32'(e.c));
        chk("paridade_ok", 32'(paridade_ok), 32'(e.ok));
        chk("erro_stop", 32'(erro_stop), 32'(e.es));
        chk("tem_on_pronto", 32'(tem_dado), 32'd1);
      end
    end
  end
  initial begin
    tab[0] = '{7'h35, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[1] = '{7'h55, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[2] = '{7'h7E, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[3] = '{7'h7F, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[4] = '{7'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b1;
    dado_serial = 1'b1;
    limpa_man = 1'b0;
    arm_fin = 1'b0;
    repeat (20) @(negedge clock);
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_ascii", 32'(dados_ascii), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_tem", 32'(tem_dado), 32'd0);
    chk("rst_flags", 32'({paridade_ok, erro_stop}), 32'd0);
    chk("rst_rx_s", 32'(db_dado_serial), 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("idle_repouso", 32'(db_estado), 32'd1);
    n_tick = 0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{tab[i].c, tab[i].ok, tab[i].es});
      send(tab[i].c, tab[i].p, tab[i].s);
    end
    linha(1'b1, M);
    chk("ticks_5_frames", 32'(n_tick), 32'd50);
    chk("pronto_5_frames", 32'(n_pronto), 32'd5);
    chk("sb_empty_table", 32'(sb.size()), 32'd0);
    chk("tem_set", 32'(tem_dado), 32'd1);
    pulse_limpa();
    chk("tem_cleared", 32'(tem_dado), 32'd0);
    chk("ascii_held", 32'(dados_ascii), 32'h7F);
    sb.push_back('{7'h35, 1'b1, 1'b1});
    send(7'h35, 1'b0, 1'b0);
    chk("framing_inicial", 32'(db_estado), 32'd0);
    linha(1'b1, 3 * M);
    chk("framing_recover", 32'(db_estado), 32'd1);
    pulse_limpa();
    arm_fin = 1'b1;
    sb.push_back('{7'h55, 1'b1, 1'b0});
    send(7'h55, 1'b0, 1'b1);
    arm_fin = 1'b0;
    linha(1'b1, M);
    chk("limpa_vs_final", 32'(tem_dado), 32'd1);
    chk("sb_empty_err", 32'(sb.size()), 32'd0);
    np = n_pronto;
    nt = n_tick;
    linha(1'b0, 3);
    linha(1'b1, 2 * M);
    chk("glitch_tick", 32'(n_tick - nt), 32'd1);
    chk("glitch_estado", 32'(db_estado), 32'd1);
    chk("glitch_pronto", 32'(n_pronto - np), 32'd0);
    linha(1'b0, M);
    linha(1'b1, M);
    linha(1'b0, M / 2);
    chk("mid_dados", 32'(db_estado), 32'd3);
    reset = 1'b1;
    linha(1'b1, 2);
    reset = 1'b0;
    chk("abort_ascii", 32'(dados_ascii), 32'd0);
    chk("abort_flags", 32'({paridade_ok, erro_stop, tem_dado}), 32'd0);
    linha(1'b1, 2 * M);
    chk("abort_pronto", 32'(n_pronto - np), 32'd0);
    sb.push_back('{7'h2A, 1'b1, 1'b0});
    send(7'h2A, 1'b1, 1'b1);
    linha(1'b1, M);
    np = n_pronto;
    dado_serial = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    linha(1'b0, 3 * M);
    chk("low_reset_inicial", 32'(db_estado), 32'd0);
    chk("low_reset_pronto", 32'(n_pronto - np), 32'd0);
    linha(1'b1, 2 * M);
    sb.push_back('{7'h7E, 1'b1, 1'b0});
    send(7'h7E, 1'b0, 1'b1);
    linha(1'b1, 2 * M);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    chk("pronto_total", 32'(n_pronto), 32'd9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
